reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised next-generation register file with two combinational read ports, one ALU write port and one independent load-writeback port.
- Generalises the load-to-fixed-register path: a load may target any register.
- A per-register busy scoreboard tracks outstanding loads and raises a stall when an operand is still pending.
- An optional write-through bypass is included.
- Sits between decode (read ports, stall) and the execute/memory writeback paths.

Parameters:
- ADDR_W, 4, register address width; depth N = 2**ADDR_W.
- DATA_W, 8, register data width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  ALU write enable.
- wr_addr  in  ADDR_W  ALU write address.
- wr_data  in  DATA_W  ALU write data.
- ld_issue  in  1  load issued; marks ld_issue_addr busy.
- ld_issue_addr  in  ADDR_W  load destination register.
- ld_wb_valid  in  1  load data returning.
- ld_wb_addr  in  ADDR_W  load writeback address.
- ld_wb_data  in  DATA_W  load writeback data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  port A data (combinational).
- rd_data_b  out  DATA_W  port B data (combinational).
- stall  out  1  combinational; either operand pending.
- r0_out  out  DATA_W  register 0 contents.
- r1_out  out  DATA_W  register 1 contents.
- rlast_out  out  DATA_W  register N-1 contents.
- busy_vec  out  N  scoreboard, bit i = register i pending load.
- ld_conflict  out  1  registered one-cycle pulse; ld_issue to an already-busy register.

Behaviour:
- Reset (reset=1 at a clk edge): all N registers <= 0, busy_vec <= 0, ld_conflict <= 0. Writes, issues and writebacks presented in that cycle are discarded. Reset mid-load drops the outstanding load; a later ld_wb for it still writes data, and its busy clear is a no-op.
- Register update priority per address per edge: ld_wb_valid write beats wr_en write to the same address. Writes to different addresses in the same cycle both commit.
- wr_en to a busy register: data written, busy bit unchanged; the pending load later overwrites it.
- Scoreboard per edge, bit i:
  - cleared if ld_wb_valid and ld_wb_addr==i;
  - set if ld_issue and ld_issue_addr==i and bit i was 0;
  - if clear and set hit the same i in the same cycle, set wins (bit ends 1, data from wb written).
- ld_conflict: asserted for exactly one cycle, the cycle after an edge where ld_issue targeted an address whose busy bit was 1 and not cleared that cycle. The issue is ignored (busy stays 1). Otherwise ld_conflict is 0.
- Reads, BYPASS=1:
  - rd_data_x = ld_wb_data if ld_wb_valid and ld_wb_addr==rd_addr_x;
  - else wr_data if wr_en and wr_addr==rd_addr_x;
  - else stored value.
- Reads, BYPASS=0: stored value only.
- busy_x (internal) = busy_vec[rd_addr_x] and not (BYPASS and ld_wb_valid and ld_wb_addr==rd_addr_x).
- stall = busy_a | busy_b. Combinational; no state is held for stall.
- r0_out, r1_out, rlast_out and busy_vec reflect registered state only (no bypass).
- Latency: a write is visible at the read ports in the same cycle with BYPASS=1, and one cycle later with BYPASS=0.

Test Plan:
- Reset, then wr_en addr 3 data 0x5A; rd_addr_a=3 same cycle -> rd_data_a=0x5A (BYPASS=1). Next cycle, stored value reads 0x5A. With BYPASS=0, same-cycle read returns 0x00.
- ld_issue addr 7, then rd_addr_b=7 -> busy_vec[7]=1, stall=1. ld_wb_valid addr 7 data 0xC3 -> rd_data_b=0xC3 and stall=0 that cycle. Next cycle busy_vec=0.
- wr_en addr 4 data 0x11 and ld_wb_valid addr 4 data 0x22 in the same cycle -> reg4=0x22.
- ld_issue addr 2 twice on consecutive cycles -> ld_conflict=1 for exactly one cycle after the second issue; busy_vec[2] stays 1. Same-cycle ld_wb addr 2 plus ld_issue addr 2 -> no conflict, busy_vec[2]=1.
- Write 0xFF to reg N-1, 0x01 to reg0, 0x02 to reg1 -> rlast_out=0xFF, r0_out=0x01, r1_out=0x02. Assert reset with ld_issue addr 5 pending -> all outputs 0, busy_vec=0.
- Parameter sweep ADDR_W=5, DATA_W=16: write 0xBEEF to reg 31 -> rlast_out=0xBEEF; busy_vec width 32.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : 2R register file with an ALU write port, an independent load
//            writeback port, a per-register load scoreboard and optional bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 ld_issue,
    input  logic [ADDR_W-1:0]    ld_issue_addr,
    input  logic                 ld_wb_valid,
    input  logic [ADDR_W-1:0]    ld_wb_addr,
    input  logic [DATA_W-1:0]    ld_wb_data,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 stall,
    output logic [DATA_W-1:0]    r0_out,
    output logic [DATA_W-1:0]    r1_out,
    output logic [DATA_W-1:0]    rlast_out,
    output logic [2**ADDR_W-1:0] busy_vec,
    output logic                 ld_conflict
);

    localparam int   N        = 2**ADDR_W;
    localparam logic C_BYPASS = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [N];
    logic [N-1:0]      r_busy;
    logic              r_ld_conflict;

    logic [N-1:0]      w_busy_next;
    logic              w_conflict;
    logic              w_wb_hit_a;
    logic              w_wb_hit_b;
    logic              w_wr_hit_a;
    logic              w_wr_hit_b;
    logic              w_wb_over_wr;

    // A returning load owns its address this cycle, so the ALU write yields.
    assign w_wb_over_wr = ld_wb_valid && (ld_wb_addr == wr_addr);

    assign w_conflict = ld_issue && r_busy[ld_issue_addr]
                        && !(ld_wb_valid && (ld_wb_addr == ld_issue_addr));

    always_comb begin
        w_busy_next = r_busy;
        if (ld_wb_valid) begin
            w_busy_next[ld_wb_addr] = 1'b0;
        end
        if (ld_issue) begin
            w_busy_next[ld_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
            r_busy        <= '0;
            r_ld_conflict <= 1'b0;
        end else begin
            if (ld_wb_valid) begin
                r_regs[ld_wb_addr] <= ld_wb_data;
            end
            if (wr_en && !w_wb_over_wr) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy        <= w_busy_next;
            r_ld_conflict <= w_conflict;
        end
    end

    assign w_wb_hit_a = ld_wb_valid && (ld_wb_addr == rd_addr_a);
    assign w_wb_hit_b = ld_wb_valid && (ld_wb_addr == rd_addr_b);
    assign w_wr_hit_a = wr_en && (wr_addr == rd_addr_a);
    assign w_wr_hit_b = wr_en && (wr_addr == rd_addr_b);

    generate
        if (BYPASS != 0) begin : g_bypass
            assign rd_data_a = w_wb_hit_a ? ld_wb_data :
                               w_wr_hit_a ? wr_data    : r_regs[rd_addr_a];
            assign rd_data_b = w_wb_hit_b ? ld_wb_data :
                               w_wr_hit_b ? wr_data    : r_regs[rd_addr_b];
        end else begin : g_no_bypass
            assign rd_data_a = r_regs[rd_addr_a];
            assign rd_data_b = r_regs[rd_addr_b];
        end
    endgenerate

    // A forwarded load result satisfies the operand, so it no longer stalls.
    assign stall = (r_busy[rd_addr_a] && !(C_BYPASS && w_wb_hit_a))
                || (r_busy[rd_addr_b] && !(C_BYPASS && w_wb_hit_b));

    assign r0_out      = r_regs[0];
    assign r1_out      = r_regs[1];
    assign rlast_out   = r_regs[N-1];
    assign busy_vec    = r_busy;
    assign ld_conflict = r_ld_conflict;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Vector-table bench for reg_file_sb (bypass, no-bypass, wide cfg).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, ld_issue, ld_wb_valid;
    logic [3:0]  wr_addr, ld_issue_addr, ld_wb_addr, rd_addr_a, rd_addr_b;
    logic [7:0]  wr_data, ld_wb_data;
    logic [7:0]  rd_data_a, rd_data_b, r0_out, r1_out, rlast_out;
    logic        stall, ld_conflict;
    logic [15:0] busy_vec;

    logic [7:0]  nb_rd_data_a, nb_rd_data_b, nb_r0, nb_r1, nb_rlast;
    logic        nb_stall, nb_conflict;
    logic [15:0] nb_busy;

    logic        w_wr_en, w_ld_issue, w_ld_wb_valid;
    logic [4:0]  w_wr_addr, w_ld_issue_addr, w_ld_wb_addr, w_rd_addr_a, w_rd_addr_b;
    logic [15:0] w_wr_data, w_ld_wb_data;
    logic [15:0] w_rd_data_a, w_rd_data_b, w_r0, w_r1, w_rlast;
    logic        w_stall, w_conflict;
    logic [31:0] w_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.ADDR_W(4), .DATA_W(8), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
        .ld_wb_valid(ld_wb_valid), .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .stall(stall),
        .r0_out(r0_out), .r1_out(r1_out), .rlast_out(rlast_out),
        .busy_vec(busy_vec), .ld_conflict(ld_conflict)
    );

    reg_file_sb #(.ADDR_W(4), .DATA_W(8), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
        .ld_wb_valid(ld_wb_valid), .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b), .stall(nb_stall),
        .r0_out(nb_r0), .r1_out(nb_r1), .rlast_out(nb_rlast),
        .busy_vec(nb_busy), .ld_conflict(nb_conflict)
    );

    reg_file_sb #(.ADDR_W(5), .DATA_W(16), .BYPASS(1)) dut_w (
        .clk(clk), .reset(reset),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .ld_issue(w_ld_issue), .ld_issue_addr(w_ld_issue_addr),
        .ld_wb_valid(w_ld_wb_valid), .ld_wb_addr(w_ld_wb_addr), .ld_wb_data(w_ld_wb_data),
        .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b), .stall(w_stall),
        .r0_out(w_r0), .r1_out(w_r1), .rlast_out(w_rlast),
        .busy_vec(w_busy), .ld_conflict(w_conflict)
    );

    // Field order: inputs, then outputs expected before the following edge.
    typedef struct {
        int we, wa, wd, li, lia, wbv, wba, wbd, ra, rb;
        int ea, eb, es, ebusy, ec, nba, nbs, r0, r1, rl;
    } vec_t;

    vec_t vecs [18];
    vec_t sb [$];
    vec_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ld_issue = 1'b0; ld_issue_addr = '0;
        ld_wb_valid = 1'b0; ld_wb_addr = '0; ld_wb_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            //  we wa  wd  li lia wbv wba wbd  ra rb   ea    eb  es ebusy  ec nba  nbs r0 r1 rl
            '{1, 3, 'h5A, 0, 0, 0, 0, 0,    3, 0,  'h5A, 0,    0, 'h00, 0, 0,    0, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    3, 3,  'h5A, 'h5A, 0, 'h00, 0, 'h5A, 0, 0, 0, 0},
            '{0, 0, 0,    1, 7, 0, 0, 0,    3, 7,  'h5A, 0,    0, 'h00, 0, 'h5A, 0, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    0, 7,  0,    0,    1, 'h80, 0, 0,    1, 0, 0, 0},
            '{0, 0, 0,    0, 0, 1, 7, 'hC3, 7, 7,  'hC3, 'hC3, 0, 'h80, 0, 0,    1, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    7, 3,  'hC3, 'h5A, 0, 'h00, 0, 'hC3, 0, 0, 0, 0},
            '{1, 4, 'h11, 0, 0, 1, 4, 'h22, 4, 0,  'h22, 0,    0, 'h00, 0, 0,    0, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    4, 0,  'h22, 0,    0, 'h00, 0, 'h22, 0, 0, 0, 0},
            '{0, 0, 0,    1, 2, 0, 0, 0,    2, 2,  0,    0,    0, 'h00, 0, 0,    0, 0, 0, 0},
            '{0, 0, 0,    1, 2, 0, 0, 0,    2, 2,  0,    0,    1, 'h04, 0, 0,    1, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    0, 0,  0,    0,    0, 'h04, 1, 0,    0, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    0, 0,  0,    0,    0, 'h04, 0, 0,    0, 0, 0, 0},
            '{0, 0, 0,    1, 2, 1, 2, 'h33, 2, 0,  'h33, 0,    0, 'h04, 0, 0,    1, 0, 0, 0},
            '{0, 0, 0,    0, 0, 0, 0, 0,    2, 0,  'h33, 0,    1, 'h04, 0, 'h33, 1, 0, 0, 0},
            '{1, 15,'hFF, 0, 0, 1, 2, 'h44, 15,2,  'hFF, 'h44, 0, 'h04, 0, 0,    1, 0, 0, 0},
            '{1, 0, 'h01, 0, 0, 0, 0, 0,    15,0,  'hFF, 'h01, 0, 'h00, 0, 'hFF, 0, 0, 0, 'hFF},
            '{1, 1, 'h02, 0, 0, 0, 0, 0,    1, 0,  'h02, 'h01, 0, 'h00, 0, 0,    0, 1, 0, 'hFF},
            '{0, 0, 0,    1, 5, 0, 0, 0,    0, 1,  'h01, 'h02, 0, 'h00, 0, 'h01, 0, 1, 2, 'hFF}
        };

        idle();
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_ld_issue = 1'b0; w_ld_issue_addr = '0;
        w_ld_wb_valid = 1'b0; w_ld_wb_addr = '0; w_ld_wb_data = '0;
        w_rd_addr_a = '0; w_rd_addr_b = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_r0",       32'(r0_out), 32'h0);
        check("reset_rlast",    32'(rlast_out), 32'h0);
        check("reset_busy",     32'(busy_vec), 32'h0);
        check("reset_conflict", 32'(ld_conflict), 32'h0);
        check("reset_stall",    32'(stall), 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            wr_en         = vecs[i].we[0];
            wr_addr       = vecs[i].wa[3:0];
            wr_data       = vecs[i].wd[7:0];
            ld_issue      = vecs[i].li[0];
            ld_issue_addr = vecs[i].lia[3:0];
            ld_wb_valid   = vecs[i].wbv[0];
            ld_wb_addr    = vecs[i].wba[3:0];
            ld_wb_data    = vecs[i].wbd[7:0];
            rd_addr_a     = vecs[i].ra[3:0];
            rd_addr_b     = vecs[i].rb[3:0];
            sb.push_back(vecs[i]);
            #2;
            if (sb.size() == 0) begin
                check("sb_empty", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_rd_a", i),     32'(rd_data_a),    e.ea);
                check($sformatf("v%0d_rd_b", i),     32'(rd_data_b),    e.eb);
                check($sformatf("v%0d_stall", i),    32'(stall),        e.es);
                check($sformatf("v%0d_busy", i),     32'(busy_vec),     e.ebusy);
                check($sformatf("v%0d_conflict", i), 32'(ld_conflict),  e.ec);
                check($sformatf("v%0d_nb_rd_a", i),  32'(nb_rd_data_a), e.nba);
                check($sformatf("v%0d_nb_stall", i), 32'(nb_stall),     e.nbs);
                check($sformatf("v%0d_r0", i),       32'(r0_out),       e.r0);
                check($sformatf("v%0d_r1", i),       32'(r1_out),       e.r1);
                check($sformatf("v%0d_rlast", i),    32'(rlast_out),    e.rl);
            end
        end

        // Reset while load to r5 is outstanding; same-cycle traffic is dropped.
        @(negedge clk);
        idle();
        #2;
        check("pre_reset_busy5", 32'(busy_vec), 32'h0020);
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h99;
        ld_issue = 1'b1; ld_issue_addr = 4'd6;
        @(negedge clk);
        reset = 1'b0;
        idle();
        rd_addr_a = 4'd3; rd_addr_b = 4'd15;
        #2;
        check("rst_r0",       32'(r0_out), 32'h0);
        check("rst_r1",       32'(r1_out), 32'h0);
        check("rst_rlast",    32'(rlast_out), 32'h0);
        check("rst_busy",     32'(busy_vec), 32'h0);
        check("rst_conflict", 32'(ld_conflict), 32'h0);
        check("rst_rd_a",     32'(rd_data_a), 32'h0);
        check("rst_rd_b",     32'(rd_data_b), 32'h0);

        // Stale writeback after reset still lands its data.
        @(negedge clk);
        ld_wb_valid = 1'b1; ld_wb_addr = 4'd5; ld_wb_data = 8'h77;
        @(negedge clk);
        idle();
        rd_addr_a = 4'd5;
        #2;
        check("stale_wb_data", 32'(rd_data_a), 32'h77);
        check("stale_wb_busy", 32'(busy_vec), 32'h0);
        check("stale_wb_nb",   32'(nb_rd_data_a), 32'h77);

        // Wide configuration.
        @(negedge clk);
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = 16'hBEEF;
        w_ld_issue = 1'b1; w_ld_issue_addr = 5'd31;
        w_rd_addr_a = 5'd31;
        #2;
        check("wide_bypass", 32'(w_rd_data_a), 32'h0000BEEF);
        @(negedge clk);
        w_wr_en = 1'b0; w_ld_issue = 1'b0;
        #2;
        check("wide_rlast", 32'(w_rlast), 32'h0000BEEF);
        check("wide_busy",  w_busy, 32'h80000000);
        check("wide_stall", 32'(w_stall), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
